ltpi_rx_frame_lock: RTL and testbench
=====================================

Name: ltpi_rx_frame_lock

Overview:
Parametrised LTPI receive framer and alignment-lock engine. It sits between the 8b/10b decoder output and the link-training/operational state machines. It hunts for a comma, checks CRC-8 per frame and qualifies lock over several consecutive good frames. Unlike the current PHY RX, it tolerates transient errors once aligned, declares loss of alignment, requests PHY realignment and emits whole-frame valid strobes.

Parameters:
FRAME_LEN, 16, bytes per frame including comma (byte 0) and CRC (byte FRAME_LEN-1); legal range 4..32
LOCK_CNT, 2, consecutive good frames required to declare aligned; legal range 1..15
UNLOCK_CNT, 3, consecutive bad frames while aligned that cause loss of alignment; legal range 1..15
SUBTYPE_CHK, 1, if 1, frames in CHECK state must have byte 1 == 8'h00 to count as good
ERR_CNT_W, 16, width of the saturating CRC error counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sym_valid  in  1  decoded symbol strobe; may be low for any number of cycles
sym_data  in  8  decoded byte
sym_k  in  1  byte is a K-character
frm_valid  out  1  one-cycle pulse: frame complete, frm_data valid
frm_data  out  8*FRAME_LEN  byte i at bits [8i+7:8i]; held until next frm_valid
frm_crc_err  out  1  qualifies frm_valid: frame bad (CRC or comma error)
aligned  out  1  lock achieved
lock_state  out  2  0 HUNT, 1 CHECK, 2 ALIGNED
realign_req  out  1  one-cycle pulse to PHY on loss of alignment
crc_err_cnt  out  ERR_CNT_W  saturating count of bad frames seen in ALIGNED
err_cnt_clr  in  1  synchronous clear of crc_err_cnt

Behaviour:
- Interface rule: reset is asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values: frm_valid=0, frm_data=0, frm_crc_err=0, aligned=0, lock_state=HUNT, realign_req=0, crc_err_cnt=0. Internal offset, CRC and counters are 0.
- Comma: sym_k=1 and sym_data ∈ {8'hBC (K28.5), 8'hDC (K28.6)}.
- CRC-8: polynomial 0x07, init 8'h00, MSB first. Computed over bytes 0..FRAME_LEN-2 and compared to byte FRAME_LEN-1. CRC and offset advance only on sym_valid.
- Frame capture: the byte at offset o is written into a shadow buffer. When o==FRAME_LEN-1 is accepted, on the next clk:
  - frm_data <= shadow buffer, including the last byte;
  - frm_valid=1 for one cycle;
  - frm_crc_err = CRC mismatch.
  - Offset wraps to 0 and the CRC re-initialises on the same edge.
- HUNT:
  - offset idle; no frm_valid.
  - A comma resets the CRC, stores byte 0, sets offset 1 and moves to CHECK with good-count 0.
- CHECK:
  - A comma at offset≠0 restarts the frame: it becomes byte 0, offset 1, good-count 0, and there is no frm_valid for the aborted frame.
  - A non-comma at offset 0 → HUNT.
  - At frame end, a good frame (CRC ok, and subtype ok if SUBTYPE_CHK) increments good-count; when good-count reaches LOCK_CNT → ALIGNED, aligned=1 on the same edge as that frame's frm_valid.
  - At frame end, a bad frame → HUNT with good-count 0.
  - frm_valid is still emitted in CHECK.
- ALIGNED:
  - Framing is free-running on offset.
  - A comma at offset≠0, or a non-comma at offset 0, marks the current frame bad. No resync.
  - On each bad frame: bad-count++ and crc_err_cnt++ (saturating at all-ones).
  - On each good frame: bad-count=0.
  - When bad-count reaches UNLOCK_CNT: → HUNT, aligned=0, and realign_req=1 for one cycle, all on the edge that emits that frame's frm_valid.
- err_cnt_clr has priority over a simultaneous increment; the result is 0.
- sym_valid gaps never alter state, offset or CRC.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded with no frm_valid.

Test Plan:
- Reset asserted mid-frame with sym_valid toggling → all outputs at reset values, lock_state=0, no frm_valid until a new comma plus FRAME_LEN bytes.
- Idle filler, then 2 frames of 16 bytes (BC, 00, 13 data bytes, correct CRC) with random sym_valid gaps → frm_valid twice, frm_crc_err=0, aligned=1 on the 2nd frm_valid, lock_state=2.
- In CHECK, one frame with the CRC byte XOR 8'h01 → frm_valid with frm_crc_err=1, lock_state=0, aligned stays 0; relock then needs 2 more good frames.
- ALIGNED with sequence bad, bad, good, bad, bad → aligned stays 1, crc_err_cnt=4, no realign_req.
- ALIGNED with 3 consecutive bad frames (K28.5 injected at offset 5) → realign_req one-cycle pulse, aligned=0, lock_state=0 on the 3rd frm_valid.
- SUBTYPE_CHK=1 with byte 1 = 8'h05 in CHECK → frame counted bad, lock_state=0. Separately, crc_err_cnt preloaded to 16'hFFFF plus a bad frame → stays 16'hFFFF; err_cnt_clr together with a bad frame → 0.

Source files
------------

// File: rtl/ltpi_rx_frame_lock_if.sv
// Symbol-in / frame-out bus of the LTPI receive framer.
// Handshake: sym_valid qualifies sym_data and sym_k for exactly the cycle it is
// high; there is no backpressure, so a byte is consumed on every clk edge where
// sym_valid=1. frm_valid is a one-cycle strobe that qualifies frm_crc_err;
// frm_data stays stable until the next frm_valid.
interface ltpi_rx_frame_lock_if #(
  parameter int FRAME_LEN = 16
);
  logic                   sym_valid;
  logic [7:0]             sym_data;
  logic                   sym_k;
  logic                   frm_valid;
  logic [8*FRAME_LEN-1:0] frm_data;
  logic                   frm_crc_err;

  modport master (
    output sym_valid, sym_data, sym_k,
    input  frm_valid, frm_data, frm_crc_err
  );

  modport slave (
    input  sym_valid, sym_data, sym_k,
    output frm_valid, frm_data, frm_crc_err
  );
endinterface

// File: rtl/ltpi_rx_frame_lock.sv
// LTPI receive framer: comma hunt, CRC-8 per frame, lock qualification over
// consecutive good frames and loss-of-alignment detection once locked.
module ltpi_rx_frame_lock #(
  parameter int FRAME_LEN   = 16,
  parameter int LOCK_CNT    = 2,
  parameter int UNLOCK_CNT  = 3,
  parameter int SUBTYPE_CHK = 1,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ltpi_rx_frame_lock_if.slave    bus,
  output logic                   aligned,
  output logic [1:0]             lock_state,
  output logic                   realign_req,
  output logic [ERR_CNT_W-1:0]   crc_err_cnt,
  input  logic                   err_cnt_clr
);

  localparam int OFF_W = $clog2(FRAME_LEN);
  localparam int LAST  = FRAME_LEN - 1;
  localparam int DW    = 8 * FRAME_LEN;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CHECK   = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t           state;
  logic [OFF_W-1:0] offset;
  logic [7:0]       crc;
  logic [3:0]       good_cnt;
  logic [3:0]       bad_cnt;
  logic             frame_err;   // comma placement error seen earlier in this frame
  logic [DW-1:0]    shadow;

  logic          is_comma;
  logic          at_start;
  logic          at_last;
  logic          crc_ok;
  logic          sub_ok;
  logic          pos_err;
  logic          aligned_bad;
  logic          err_inc;
  logic [DW-1:0] frame_out;

  // CRC-8, polynomial 0x07, MSB of the byte shifted in first
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  assign lock_state = state;

  // Per-byte classification of the incoming symbol against the current offset
  always_comb begin
    is_comma    = bus.sym_k && ((bus.sym_data == 8'hBC) || (bus.sym_data == 8'hDC));
    at_start    = (offset == '0);
    at_last     = (offset == OFF_W'(LAST));
    crc_ok      = (crc == bus.sym_data);
    sub_ok      = (SUBTYPE_CHK == 0) || (shadow[15:8] == 8'h00);
    pos_err     = (at_start != is_comma);
    aligned_bad = frame_err || pos_err || !crc_ok;
    err_inc     = bus.sym_valid && (state == ALIGNED) && at_last && aligned_bad;
    frame_out   = shadow;
    frame_out[LAST*8 +: 8] = bus.sym_data;
  end

  // Lock FSM, framing counters, frame output registers and error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HUNT;
      offset          <= '0;
      crc             <= 8'h00;
      good_cnt        <= 4'd0;
      bad_cnt         <= 4'd0;
      frame_err       <= 1'b0;
      shadow          <= '0;
      bus.frm_valid   <= 1'b0;
      bus.frm_data    <= '0;
      bus.frm_crc_err <= 1'b0;
      aligned         <= 1'b0;
      realign_req     <= 1'b0;
      crc_err_cnt     <= '0;
    end else begin
      bus.frm_valid <= 1'b0;
      realign_req   <= 1'b0;

      // Clear wins over a same-cycle increment
      if (err_cnt_clr)                       crc_err_cnt <= '0;
      else if (err_inc && (crc_err_cnt != '1)) crc_err_cnt <= crc_err_cnt + 1'b1;

      if (bus.sym_valid) begin
        case (state)
          HUNT: begin
            if (is_comma) begin
              shadow[7:0] <= bus.sym_data;
              crc         <= crc8_step(8'h00, bus.sym_data);
              offset      <= OFF_W'(1);
              good_cnt    <= 4'd0;
              frame_err   <= 1'b0;
              state       <= CHECK;
            end
          end

          CHECK: begin
            if (is_comma && !at_start) begin
              // Misplaced comma: abandon the partial frame and start over here
              shadow[7:0] <= bus.sym_data;
              crc         <= crc8_step(8'h00, bus.sym_data);
              offset      <= OFF_W'(1);
              good_cnt    <= 4'd0;
            end else if (at_start && !is_comma) begin
              state    <= HUNT;
              good_cnt <= 4'd0;
            end else if (at_last) begin
              offset          <= '0;
              crc             <= 8'h00;
              bus.frm_valid   <= 1'b1;
              bus.frm_data    <= frame_out;
              bus.frm_crc_err <= !crc_ok;
              if (crc_ok && sub_ok) begin
                if ((good_cnt + 4'd1) == 4'(LOCK_CNT)) begin
                  state    <= ALIGNED;
                  aligned  <= 1'b1;
                  good_cnt <= 4'd0;
                  bad_cnt  <= 4'd0;
                end else begin
                  good_cnt <= good_cnt + 4'd1;
                end
              end else begin
                state    <= HUNT;
                good_cnt <= 4'd0;
              end
            end else begin
              shadow[offset*8 +: 8] <= bus.sym_data;
              offset                <= offset + 1'b1;
              crc                   <= crc8_step(crc, bus.sym_data);
            end
          end

          ALIGNED: begin
            // Free-running framing: comma errors only taint the frame
            if (at_last) begin
              offset          <= '0;
              crc             <= 8'h00;
              frame_err       <= 1'b0;
              bus.frm_valid   <= 1'b1;
              bus.frm_data    <= frame_out;
              bus.frm_crc_err <= aligned_bad;
              if (aligned_bad) begin
                if ((bad_cnt + 4'd1) == 4'(UNLOCK_CNT)) begin
                  state       <= HUNT;
                  aligned     <= 1'b0;
                  realign_req <= 1'b1;
                  bad_cnt     <= 4'd0;
                end else begin
                  bad_cnt <= bad_cnt + 4'd1;
                end
              end else begin
                bad_cnt <= 4'd0;
              end
            end else begin
              shadow[offset*8 +: 8] <= bus.sym_data;
              offset                <= offset + 1'b1;
              crc                   <= crc8_step(crc, bus.sym_data);
              if (pos_err) frame_err <= 1'b1;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltpi_rx_frame_lock.sv
// Directed bench for ltpi_rx_frame_lock: reset corner cases by hand, then a
// table of whole frames with the expected status after each frm_valid.
module tb_ltpi_rx_frame_lock;

  localparam int FL     = 16;
  localparam int LOCK   = 2;
  localparam int UNLOCK = 3;
  localparam int CW     = 3;   // narrow error counter so saturation is reachable
  localparam int DW     = 8 * FL;
  localparam int NV     = 25;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          aligned;
  logic [1:0]    lock_state;
  logic          realign_req;
  logic [CW-1:0] crc_err_cnt;
  logic          err_cnt_clr;

  always #5 clk = ~clk;

  ltpi_rx_frame_lock_if #(.FRAME_LEN(FL)) bus ();

  ltpi_rx_frame_lock #(
    .FRAME_LEN   (FL),
    .LOCK_CNT    (LOCK),
    .UNLOCK_CNT  (UNLOCK),
    .SUBTYPE_CHK (1),
    .ERR_CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .aligned     (aligned),
    .lock_state  (lock_state),
    .realign_req (realign_req),
    .crc_err_cnt (crc_err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  // ---------------- vector table ----------------
  typedef enum logic [1:0] {K_GOOD, K_CRC, K_COMMA, K_SUB} kind_t;

  typedef struct {
    kind_t         kind;
    logic          clr;
    logic          chk_err;
    logic          err;
    logic          al;
    logic [1:0]    ls;
    logic          rr;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic          al;
    logic [1:0]    ls;
    logic          rr;
    logic [CW-1:0] cnt;
  } obs_t;

  vec_t          vecs[NV];
  obs_t          obs_q[$];
  obs_t          mon;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp;

  int n_checks       = 0;
  int n_pass         = 0;
  int frames_seen    = 0;
  int realign_cycles = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int j = 0; j < 8; j++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Capture every frame strobe and count realign cycles
  always @(negedge clk) begin
    if (bus.frm_valid === 1'b1) begin
      mon.data = bus.frm_data;
      mon.err  = bus.frm_crc_err;
      mon.al   = aligned;
      mon.ls   = lock_state;
      mon.rr   = realign_req;
      mon.cnt  = crc_err_cnt;
      obs_q.push_back(mon);
      frames_seen++;
    end
    if (realign_req === 1'b1) realign_cycles++;
  end

  // ---------------- driver tasks ----------------
  // Random gaps carry a comma-looking byte to prove sym_valid=0 is ignored
  task automatic drive_byte(input logic [7:0] d, input logic k, input logic clr);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk); #1;
      bus.sym_valid = 1'b0;
      bus.sym_data  = 8'hBC;
      bus.sym_k     = 1'b1;
      err_cnt_clr   = 1'b0;
    end
    @(posedge clk); #1;
    bus.sym_valid = 1'b1;
    bus.sym_data  = d;
    bus.sym_k     = k;
    err_cnt_clr   = clr;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    bus.sym_k     = 1'b0;
    err_cnt_clr   = 1'b0;
  endtask

  task automatic send_frame(input kind_t kind, input logic clr);
    logic [7:0]    fb[FL];
    logic          fk[FL];
    logic [7:0]    c;
    logic [DW-1:0] pk;
    fb[0] = ($urandom_range(0, 1) == 0) ? 8'hBC : 8'hDC;
    fk[0] = 1'b1;
    fb[1] = (kind == K_SUB) ? 8'h05 : 8'h00;
    fk[1] = 1'b0;
    for (int i = 2; i < FL - 1; i++) begin
      fb[i] = 8'($urandom_range(0, 255));
      fk[i] = 1'b0;
    end
    if (kind == K_COMMA) begin
      fb[5] = 8'hBC;
      fk[5] = 1'b1;
    end
    c = 8'h00;
    for (int i = 0; i < FL - 1; i++) c = crc8_ref(c, fb[i]);
    fb[FL-1] = (kind == K_CRC) ? (c ^ 8'h01) : c;
    fk[FL-1] = 1'b0;
    for (int i = 0; i < FL; i++) pk[i*8 +: 8] = fb[i];
    exp_q.push_back(pk);
    for (int i = 0; i < FL; i++) drive_byte(fb[i], fk[i], clr && (i == FL - 1));
    idle();
  endtask

  task automatic expect_frame(input vec_t v, input int idx);
    int            t;
    obs_t          o;
    logic [DW-1:0] e;
    t = 0;
    while (obs_q.size() == 0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      n_checks++;
      $display("FAIL frame%0d_timeout: got no frm_valid expected one", idx);
    end else begin
      o = obs_q.pop_front();
      last_exp = e;
      check_data($sformatf("frame%0d_data", idx), o.data, e);
      if (v.chk_err) check($sformatf("frame%0d_crc_err", idx), 32'(o.err), 32'(v.err));
      check($sformatf("frame%0d_aligned", idx), 32'(o.al), 32'(v.al));
      check($sformatf("frame%0d_lock_state", idx), 32'(o.ls), 32'(v.ls));
      check($sformatf("frame%0d_realign", idx), 32'(o.rr), 32'(v.rr));
      check($sformatf("frame%0d_err_cnt", idx), 32'(o.cnt), 32'(v.cnt));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_frm_valid"},   32'(bus.frm_valid),   32'd0);
    check_data({tag, "_frm_data"}, bus.frm_data, '0);
    check({tag, "_frm_crc_err"}, 32'(bus.frm_crc_err), 32'd0);
    check({tag, "_aligned"},     32'(aligned),         32'd0);
    check({tag, "_lock_state"},  32'(lock_state),      32'd0);
    check({tag, "_realign"},     32'(realign_req),     32'd0);
    check({tag, "_err_cnt"},     32'(crc_err_cnt),     32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish within 200us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    // kind, clr, chk_err, err, aligned, lock_state, realign, err_cnt
    vecs[0]  = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0};
    vecs[1]  = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0};
    vecs[2]  = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0};
    vecs[3]  = '{K_SUB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    vecs[4]  = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0};
    vecs[5]  = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0};
    vecs[6]  = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd1};
    vecs[7]  = '{K_COMMA, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd2};
    vecs[8]  = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd2};
    vecs[9]  = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd3};
    vecs[10] = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd4};
    vecs[11] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd4};
    vecs[12] = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd5};
    vecs[13] = '{K_COMMA, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd6};
    vecs[14] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd6};
    vecs[15] = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd7};
    vecs[16] = '{K_CRC,   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd7};
    vecs[17] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd7};
    vecs[18] = '{K_CRC,   1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd0};
    vecs[19] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0};
    vecs[20] = '{K_COMMA, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd1};
    vecs[21] = '{K_COMMA, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'd2};
    vecs[22] = '{K_COMMA, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'd3};
    vecs[23] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
    vecs[24] = '{K_GOOD,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd3};

    reset         = 1'b1;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 8'h00;
    bus.sym_k     = 1'b0;
    err_cnt_clr   = 1'b0;
    last_exp      = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Filler without a comma keeps the framer hunting
    for (int i = 0; i < 6; i++) drive_byte(8'h4A, 1'b0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("filler_lock_state", 32'(lock_state), 32'd0);
    check("filler_no_frame", 32'(frames_seen), 32'd0);

    // Partial frame, then asynchronous reset while sym_valid toggles
    drive_byte(8'hBC, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("partial_lock_state", 32'(lock_state), 32'd1);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.sym_valid = ~bus.sym_valid;
      bus.sym_data  = 8'hBC;
      bus.sym_k     = 1'b1;
    end
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_k     = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_lock_state", 32'(lock_state), 32'd0);
    check("post_reset_no_frame", 32'(frames_seen), 32'd0);

    // Comma plus a few bytes; the first table frame's comma must restart it
    drive_byte(8'hDC, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle();

    for (int v = 0; v < NV; v++) begin
      send_frame(vecs[v].kind, vecs[v].clr);
      expect_frame(vecs[v], v);
    end

    repeat (4) @(negedge clk);
    check("total_frames", 32'(frames_seen), 32'(NV));
    check("extra_frames", 32'(obs_q.size()), 32'd0);
    check("realign_cycles", 32'(realign_cycles), 32'd1);
    check_data("frm_data_held", bus.frm_data, last_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
